// File: rtl/slot_alloc_bitmap_pkg.sv
// Shared pool sizing and index type for the slot allocator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package slot_alloc_bitmap_pkg;

  localparam int POOL_DEPTH = 32;
  localparam int POOL_IDX_W = $clog2(POOL_DEPTH);
  localparam int POOL_CNT_W = $clog2(POOL_DEPTH) + 1;

  typedef logic [POOL_IDX_W-1:0] pool_idx_t;

endpackage

// File: rtl/slot_alloc_bitmap_index_decoder.sv
// Index + valid to one-hot pool mask, used once per release port.
// Latency: combinational.
// Backpressure: none; a low valid yields an all-zero mask.
module slot_index_decoder #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             vld,
  input  logic [IDX_W-1:0] idx,
  output logic [DEPTH-1:0] mask
);

  // Compare against every slot position so indices past DEPTH-1 decode to nothing.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask[i] = vld && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/slot_alloc_bitmap.sv
// Free-bitmap allocator: grants the lowest free slot, takes slots back on two release ports.
// Latency: grant/index combinational from the registered map; map/count update on the next edge.
// Backpressure: no grant while empty or flushing; the consumer simply holds alloc_req and retries.
module slot_alloc_bitmap
  import slot_alloc_bitmap_pkg::*;
#(
  parameter int DEPTH = POOL_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               alloc_req,
  output logic               alloc_gnt,
  output logic [IDX_W-1:0]   alloc_idx,
  input  logic [1:0]         rel_valid,
  input  logic [2*IDX_W-1:0] rel_idx,
  output logic [CNT_W-1:0]   free_cnt,
  output logic               empty,
  output logic               full_free,
  output logic               err_dbl_free
);

  logic [DEPTH-1:0] free_map;
  logic [DEPTH-1:0] free_map_nxt;
  logic [DEPTH-1:0] alloc_mask;
  logic [DEPTH-1:0] rel_mask0;
  logic [DEPTH-1:0] rel_mask1;
  logic [CNT_W-1:0] free_cnt_nxt;
  logic [IDX_W-1:0] rel_idx0;
  logic [IDX_W-1:0] rel_idx1;
  logic             map_any;
  logic             rel_dup;
  logic             rel_acc0;
  logic             rel_acc1;
  logic             dbl_hit;

  assign rel_idx0 = rel_idx[IDX_W-1:0];
  assign rel_idx1 = rel_idx[2*IDX_W-1:IDX_W];

  // A release is accepted only if the slot is currently allocated; port1 loses a same-index tie.
  assign rel_dup  = rel_valid[0] && rel_valid[1] && (rel_idx0 == rel_idx1);
  assign rel_acc0 = rel_valid[0] && !free_map[rel_idx0];
  assign rel_acc1 = rel_valid[1] && !free_map[rel_idx1] && !rel_dup;
  assign dbl_hit  = (rel_valid[0] && free_map[rel_idx0]) ||
                    (rel_valid[1] && free_map[rel_idx1]) || rel_dup;

  // Decoders are fed the accept qualifiers so rejected releases never touch the map.
  slot_index_decoder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rel_dec0 (
    .vld  (rel_acc0),
    .idx  (rel_idx0),
    .mask (rel_mask0)
  );

  slot_index_decoder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_rel_dec1 (
    .vld  (rel_acc1),
    .idx  (rel_idx1),
    .mask (rel_mask1)
  );

  // Lowest-index free slot from the registered map only (no same-cycle release bypass).
  always_comb begin
    alloc_idx = '0;
    map_any   = |free_map;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_map[i]) alloc_idx = IDX_W'(i);
    end
    alloc_gnt = alloc_req && map_any && !flush;
  end

  // Clear the granted slot, set accepted releases; a granted slot is free so it cannot be released too.
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      alloc_mask[i] = alloc_gnt && (alloc_idx == IDX_W'(i));
    end
    free_map_nxt = (free_map & ~alloc_mask) | rel_mask0 | rel_mask1;
    free_cnt_nxt = free_cnt - CNT_W'(alloc_gnt) + CNT_W'(rel_acc0) + CNT_W'(rel_acc1);
  end

  // Pool state registers; flush overrides any allocate/release in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_map     <= '1;
      free_cnt     <= CNT_W'(DEPTH);
      err_dbl_free <= 1'b0;
    end else if (flush) begin
      free_map     <= '1;
      free_cnt     <= CNT_W'(DEPTH);
      err_dbl_free <= 1'b0;
    end else begin
      free_map     <= free_map_nxt;
      free_cnt     <= free_cnt_nxt;
      if (dbl_hit) err_dbl_free <= 1'b1;
    end
  end

  assign empty     = (free_cnt == '0);
  assign full_free = (free_cnt == CNT_W'(DEPTH));

  a_cnt_matches_map: assert property (@(posedge clk) disable iff (!rst_n)
    free_cnt == CNT_W'($countones(free_map)));

endmodule

// File: tb/tb_slot_alloc_bitmap.sv
// Scoreboard bench for slot_alloc_bitmap with a set-based reference model.
module tb_slot_alloc_bitmap;
  import slot_alloc_bitmap_pkg::*;

  localparam int D  = POOL_DEPTH;
  localparam int IW = POOL_IDX_W;
  localparam int CW = POOL_CNT_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [IW-1:0] alloc_idx;
  logic [1:0]    rel_valid;
  logic [2*IW-1:0] rel_idx;
  logic [CW-1:0] free_cnt;
  logic          empty;
  logic          full_free;
  logic          err_dbl_free;

  slot_alloc_bitmap dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx    (alloc_idx),
    .rel_valid    (rel_valid),
    .rel_idx      (rel_idx),
    .free_cnt     (free_cnt),
    .empty        (empty),
    .full_free    (full_free),
    .err_dbl_free (err_dbl_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit gnt;
    int idx;
    int cnt;
    bit empty;
    bit full;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  bit   m_free[D];
  bit   m_err;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_free[i]) c++;
    return c;
  endfunction

  function automatic int m_lowest();
    for (int i = 0; i < D; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < D; i++) m_free[i] = 1'b1;
    m_err = 1'b0;
  endtask

  // One clock cycle of stimulus: drive, push the expected response, then advance the model.
  task automatic step(input bit fl, input bit req, input bit [1:0] rv, input int i0, input int i1);
    exp_t e;
    int   lo;
    bit   do0;
    bit   do1;
    @(posedge clk);
    #1;
    flush     = fl;
    alloc_req = req;
    rel_valid = rv;
    rel_idx   = {pool_idx_t'(i1), pool_idx_t'(i0)};
    lo      = m_lowest();
    e.gnt   = req && !fl && (lo >= 0);
    e.idx   = (lo < 0) ? 0 : lo;
    e.cnt   = m_count();
    e.empty = (e.cnt == 0);
    e.full  = (e.cnt == D);
    e.err   = m_err;
    sb_q.push_back(e);
    if (fl) begin
      m_reset();
    end else begin
      do0 = rv[0] && !m_free[i0];
      do1 = rv[1] && !m_free[i1] && !(rv[0] && (i0 == i1));
      if ((rv[0] && !do0) || (rv[1] && !do1)) m_err = 1'b1;
      if (e.gnt) m_free[lo] = 1'b0;
      if (do0) m_free[i0] = 1'b1;
      if (do1) m_free[i1] = 1'b1;
    end
  endtask

  // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_gnt",   int'(alloc_gnt),    int'(mon_e.gnt));
        chk("sb_idx",   int'(alloc_idx),    mon_e.idx);
        chk("sb_cnt",   int'(free_cnt),     mon_e.cnt);
        chk("sb_empty", int'(empty),        int'(mon_e.empty));
        chk("sb_full",  int'(full_free),    int'(mon_e.full));
        chk("sb_err",   int'(err_dbl_free), int'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    alloc_req = 1'b0;
    rel_valid = 2'b00;
    rel_idx   = '0;
    m_reset();
    #12;
    chk("rst_cnt",   int'(free_cnt),     32);
    chk("rst_full",  int'(full_free),    1);
    chk("rst_empty", int'(empty),        0);
    chk("rst_gnt",   int'(alloc_gnt),    0);
    chk("rst_idx",   int'(alloc_idx),    0);
    chk("rst_err",   int'(err_dbl_free), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back allocation drains the pool in index order.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 2'b00, 0, 0);
      @(negedge clk);
      chk("seq_gnt", int'(alloc_gnt), 1);
      chk("seq_idx", int'(alloc_idx), i);
    end
    step(0, 1, 2'b00, 0, 0);
    @(negedge clk);
    chk("drain_gnt",   int'(alloc_gnt), 0);
    chk("drain_empty", int'(empty),     1);
    chk("drain_cnt",   int'(free_cnt),  0);

    // Release while empty is not bypassed to the same-cycle grant.
    step(0, 1, 2'b01, 5, 0);
    @(negedge clk);
    chk("nobypass_gnt", int'(alloc_gnt), 0);
    step(0, 1, 2'b00, 0, 0);
    @(negedge clk);
    chk("rel5_gnt", int'(alloc_gnt), 1);
    chk("rel5_idx", int'(alloc_idx), 5);

    // Allocate 0..7, then allocate with two releases in the same cycle.
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b00, 0, 0);
    step(0, 1, 2'b11, 3, 6);
    @(negedge clk);
    chk("mix_idx", int'(alloc_idx), 8);
    step(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("mix_cnt", int'(free_cnt), 25);

    // Double free of a free slot, then both ports naming the same allocated slot.
    step(0, 0, 2'b01, 10, 0);
    step(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("dbl_err", int'(err_dbl_free), 1);
    chk("dbl_cnt", int'(free_cnt),     25);
    step(0, 0, 2'b11, 4, 4);
    step(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("dup_cnt", int'(free_cnt),     26);
    chk("dup_err", int'(err_dbl_free), 1);

    // Flush beats a same-cycle allocate and double release.
    step(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 2'b00, 0, 0);
    step(0, 1, 2'b01, 25, 0);
    step(1, 1, 2'b11, 2, 9);
    @(negedge clk);
    chk("flush_gnt",     int'(alloc_gnt),    0);
    chk("flush_err_pre", int'(err_dbl_free), 1);
    step(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    chk("flush_cnt",  int'(free_cnt),     32);
    chk("flush_full", int'(full_free),    1);
    chk("flush_err",  int'(err_dbl_free), 0);
    chk("flush_idx",  int'(alloc_idx),    0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
           2'($urandom_range(0, 3)), $urandom_range(0, D - 1), $urandom_range(0, D - 1));
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) step(0, 1, (i == 2) ? 2'b01 : 2'b00, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt",   int'(free_cnt),     32);
    chk("arst_full",  int'(full_free),    1);
    chk("arst_empty", int'(empty),        0);
    chk("arst_err",   int'(err_dbl_free), 0);
    flush     = 1'b0;
    alloc_req = 1'b0;
    rel_valid = 2'b00;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 0, 0);
    step(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
